// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: lock input, count clear and reset/status outputs of the lock sequencer.
interface pll_lock_sequencer_if #(parameter int CNT_W = 8);
  logic locked_in;
  logic clear_count;
  logic sys_reset_n;
  logic ready;
  logic [1:0] state;
  logic [CNT_W-1:0] loss_count;
  modport master(output locked_in, clear_count, input sys_reset_n, ready, state, loss_count);
  modport slave(input locked_in, clear_count, output sys_reset_n, ready, state, loss_count);
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: qualifies PLL lock, then releases the system reset and counts in-service lock losses.
module pll_lock_sequencer #(
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W = 8
) (
  input logic clock,
  input logic reset_n,
  pll_lock_sequencer_if.slave bus
);
  localparam int MAXC = LOCK_CYCLES > HOLD_CYCLES ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  typedef enum logic [1:0] {UNLOCKED = 2'd0, QUALIFY = 2'd1, HOLD = 2'd2, RUN = 2'd3} state_t;
  state_t cur, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] sync;
  logic [CNT_W-1:0] lc, lc_nxt;
  logic lk_s, loss, run_q;
  assign lk_s = sync[1];
  assign loss = cur == RUN && !lk_s;
  assign lc_nxt = bus.clear_count ? CNT_W'(loss) : (loss && lc != '1) ? lc + CNT_W'(1) : lc;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sync <= '0;
      cur <= UNLOCKED;
      cnt <= '0;
      lc <= '0;
      run_q <= 1'b0;
    end else begin
      sync <= {sync[0], bus.locked_in};
      cur <= nxt;
      cnt <= cnt_nxt;
      lc <= lc_nxt;
      run_q <= nxt == RUN;
    end
  // cnt stays zero outside the counted states, so every state change clears it
  always_comb begin
    nxt = cur;
    cnt_nxt = '0;
    case (cur)
      UNLOCKED: nxt = lk_s ? QUALIFY : UNLOCKED;
      QUALIFY:
        if (!lk_s) nxt = UNLOCKED;
        else if (cnt == CW'(LOCK_CYCLES - 1)) nxt = HOLD;
        else cnt_nxt = cnt + CW'(1);
      HOLD:
        if (!lk_s) nxt = UNLOCKED;
        else if (cnt == CW'(HOLD_CYCLES - 1)) nxt = RUN;
        else cnt_nxt = cnt + CW'(1);
      RUN: nxt = lk_s ? RUN : UNLOCKED;
    endcase
  end
  assign bus.sys_reset_n = run_q;
  assign bus.ready = run_q;
  assign bus.state = cur;
  assign bus.loss_count = lc;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: random and directed lock patterns checked by a run-length reference model via a scoreboard.
module tb_pll_lock_sequencer;
  localparam int L = 8;
  localparam int H = 4;
  localparam int CW = 2;
  logic clock = 1'b0;
  logic reset_n;
  int total = 0;
  int passed = 0;
  pll_lock_sequencer_if #(.CNT_W(CW)) bus();
  pll_lock_sequencer #(.LOCK_CYCLES(L), .HOLD_CYCLES(H), .CNT_W(CW)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clock = ~clock;
  // Model: state follows from n, the number of consecutive edges that saw synchronized lock high
  int n;
  logic [1:0] sy;
  logic [CW-1:0] mlc;
  logic [5:0] q[$];
  logic lk, was_run, mloss;
  logic [1:0] mst;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n = 0;
      sy = 2'b00;
      mlc = '0;
      q.delete();
    end else begin
      lk = sy[1];
      was_run = n > L + H;
      n = !lk ? 0 : (n > L + H ? n : n + 1);
      mloss = was_run && !lk;
      mlc = bus.clear_count ? (mloss ? 2'd1 : 2'd0) : (mloss && mlc != 2'd3) ? mlc + 2'd1 : mlc;
      sy = {sy[0], bus.locked_in};
      mst = n == 0 ? 2'd0 : n <= L ? 2'd1 : n <= L + H ? 2'd2 : 2'd3;
      q.push_back({mst, mst == 2'd3, mst == 2'd3, mlc});
    end
  end
  logic [5:0] exp_v, act_v;
  always @(posedge clock) begin
    #1;
    if (reset_n) begin
      act_v = {bus.state, bus.sys_reset_n, bus.ready, bus.loss_count};
      total++;
      if (q.size() == 0)
        $display("FAIL scoreboard_empty t=%0t got state=%0d rst_n=%b ready=%b loss=%0d", $time,
                 act_v[5:4], act_v[3], act_v[2], act_v[1:0]);
      else begin
        exp_v = q.pop_front();
        if (act_v !== exp_v)
          $display("FAIL outputs t=%0t got state=%0d rst_n=%b ready=%b loss=%0d want state=%0d rst_n=%b ready=%b loss=%0d",
                   $time, act_v[5:4], act_v[3], act_v[2], act_v[1:0], exp_v[5:4], exp_v[3], exp_v[2], exp_v[1:0]);
        else passed++;
      end
    end
  end
  task automatic check_rst(input string name);
    logic [5:0] a;
    a = {bus.state, bus.sys_reset_n, bus.ready, bus.loss_count};
    total++;
    if (a !== 6'd0) $display("FAIL %s got outputs=%b want 000000", name, a);
    else passed++;
  endtask
  task automatic set_for(input logic l, input int cyc);
    bus.locked_in = l;
    repeat (cyc) @(negedge clock);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    reset_n = 1'b0;
    bus.locked_in = 1'b0;
    bus.clear_count = 1'b0;
    repeat (3) @(negedge clock);
    check_rst("por");
    reset_n = 1'b1;
    set_for(1'b1, 20);
    set_for(1'b0, 4);
    set_for(1'b1, 6);
    set_for(1'b0, 1);
    set_for(1'b1, 20);
    for (int i = 0; i < 4; i++) begin
      set_for(1'b0, 4);
      set_for(1'b1, 16);
    end
    bus.clear_count = 1'b1;
    @(negedge clock);
    bus.clear_count = 1'b0;
    set_for(1'b1, 2);
    bus.locked_in = 1'b0;
    repeat (2) @(negedge clock);
    bus.clear_count = 1'b1;
    @(negedge clock);
    bus.clear_count = 1'b0;
    set_for(1'b0, 2);
    set_for(1'b1, 16);
    set_for(1'b0, 4);
    set_for(1'b1, 12);
    #2;
    reset_n = 1'b0;
    #1;
    check_rst("reset_mid_hold");
    @(negedge clock);
    check_rst("reset_held");
    reset_n = 1'b1;
    set_for(1'b1, 20);
    for (int i = 0; i < 100; i++) set_for(logic'(i % 2), 1);
    for (int i = 0; i < 300; i++) begin
      bus.clear_count = $urandom_range(0, 9) == 0;
      set_for(1'b1, $urandom_range(1, 30));
      bus.clear_count = $urandom_range(0, 9) == 0;
      set_for(1'b0, $urandom_range(1, 3));
    end
    bus.clear_count = 1'b0;
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
